alu_host_driver: RTL and testbench
==================================

ALU_HOST_DRIVER -- requirements
Module: alu_host_driver

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter TIMEOUT_CYCLES, default 32, is the maximum number of cycles spent in WAIT_DONE before an error response.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 req_valid  input  1  the user presents an operation.
REQ-006 req_ready  output  1  the block can accept an operation; high only in IDLE.
REQ-007 req_a, req_b  input  32 each  FP32 operands, sampled on accept.
REQ-008 req_sub  input  1  0 = add, 1 = subtract, sampled on accept.
REQ-009 resp_valid  output  1  the result is held stable until taken.
REQ-010 resp_ready  input  1  the user takes the result.
REQ-011 resp_data  output  32  FP32 result.
REQ-012 resp_err  output  1  the transaction was aborted by a timeout or protocol error.
REQ-013 alu_start  output  1  start pulse to the byte-serial FP ALU.
REQ-014 alu_in  output  8  operand byte bus to the ALU.
REQ-015 alu_opcode  output  1  add/sub select to the ALU.
REQ-016 alu_out  input  8  result byte bus from the ALU.
REQ-017 alu_done  input  1  the ALU result byte is valid.

Function
REQ-018 States: IDLE, START, SEND, WAIT_DONE, RECV, RESP; a 3-bit byte counter is shared by SEND and RECV.
REQ-019 IDLE: on req_valid&&req_ready, latch req_a, req_b and req_sub, then go to START.
REQ-020 START: assert alu_start=1 for exactly one cycle, then go to SEND with counter=0.
REQ-021 SEND: drive alu_in registered, one byte per cycle, in this order: A[7:0], A[15:8], A[23:16], A[31:24], B[7:0], B[15:8], B[23:16], B[31:24].
REQ-022 The first SEND byte is on alu_in in the cycle immediately after the alu_start cycle.
REQ-023 After 8 SEND cycles, go to WAIT_DONE.
REQ-024 alu_opcode equals the latched sub bit from START through the end of RECV, and 0 otherwise.
REQ-025 WAIT_DONE: on alu_done=1, capture alu_out into resp_data[7:0] and go to RECV with counter=1.
REQ-026 WAIT_DONE: if alu_done is still 0 after TIMEOUT_CYCLES cycles, go to RESP with resp_err=1 and resp_data=0.
REQ-027 RECV: each cycle with alu_done=1, capture alu_out into byte[counter], LSB first.
REQ-028 RECV: after byte 3 is captured, go to RESP with resp_err=0.
REQ-029 RECV: if alu_done=0 before 4 bytes are captured, go to RESP with resp_err=1 and keep the partial bytes.
REQ-030 RESP: resp_valid=1, with resp_data and resp_err stable, until resp_valid&&resp_ready; then go to IDLE.
REQ-031 Accept-to-resp_valid latency SHALL be exactly 15 cycles with a nominal ALU:
- accept in cycle 0;
- alu_start in cycle 1;
- bytes in cycles 2-9;
- done in cycles 11-14;
- resp_valid from cycle 15.
REQ-032 In IDLE, alu_done=1 is ignored; a new START is only issued from IDLE, so the ALU is never started mid-transaction.
REQ-033 req_valid asserted outside IDLE has no effect (req_ready=0).
REQ-034 A resp_ready held high SHALL cause resp_valid to last exactly one cycle.
REQ-035 Back-to-back requests: the next accept happens no earlier than the cycle after the response handshake.
REQ-036 alu_in=0 outside SEND.

Reset
REQ-037 Asserting rst at any time, including mid-SEND or mid-RECV, SHALL immediately force:
- state=IDLE, counter=0;
- alu_start=0, alu_in=0, alu_opcode=0;
- resp_valid=0, resp_data=0, resp_err=0;
- latched operands=0.
REQ-038 req_ready=1 in the first cycle after rst deasserts.
REQ-039 The system integration ties the ALU active-low reset to the inverse of rst, so both ends reset together.

Structure
REQ-040 A shared package alu_host_pkg SHALL hold the state enumeration, BYTES_PER_OPERAND=4, OP_ADD=0, OP_SUB=1.
REQ-041 The timeout counter SHALL be implemented in one sub-module, alu_host_timer, with inputs clear and enable and output expired.

Verification (bench uses a cycle-accurate behavioural model of the byte-serial ALU)
REQ-042 Add case: req_a=0x3F800000, req_b=0x40000000, sub=0 -> alu_in sequence 00,00,80,3F,00,00,00,40; resp_data=0x40400000, resp_err=0; resp_valid in cycle 15.
REQ-043 Subtract case: req_a=0x40400000, req_b=0x3F800000, sub=1 -> alu_opcode=1 through RECV; resp_data=0x40000000.
REQ-044 Timeout: the ALU model never asserts done, TIMEOUT_CYCLES=32 -> resp_valid after 32 WAIT_DONE cycles with resp_err=1 and resp_data=0.
REQ-045 Backpressure: resp_ready held low 5 cycles -> resp_data stable, req_ready=0 throughout; the next request is accepted the cycle after the handshake.
REQ-046 Reset mid-operation: rst asserted at SEND byte 5 -> all outputs equal their reset values in the same cycle; a following request 0x3F800000+0x3F800000 -> resp_data=0x40000000.
REQ-047 Dropped done: the ALU model deasserts done after 2 bytes -> resp_err=1, resp_data[15:0] holds the 2 captured bytes, resp_data[31:16]=0.

Source files
------------

// File: rtl/alu_host_pkg.sv
// Shared types and constants for the FP ALU host driver.
// Byte-serial framing helpers live here so every stage agrees on ordering.
package alu_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT_DONE,
    RECV,
    RESP
  } state_t;

  localparam int   BYTES_PER_OPERAND = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Byte idx of the outgoing stream: A low-to-high, then B low-to-high.
  function automatic logic [7:0] send_byte(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  idx
  );
    logic [63:0] w;
    w = {b, a};
    return w[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/alu_host_timer.sv
// WAIT_DONE watchdog: counts enabled cycles, flags the last allowed one.
// expired is combinational so the FSM can leave on that very cycle.
module alu_host_timer #(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_host_driver.sv
// Host-side driver for a byte-serial FP32 add/sub ALU.
// Accepts one op, streams 8 operand bytes, gathers 4 result bytes.
module alu_host_driver
  import alu_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_sub,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        alu_start,
  output logic [7:0]  alu_in,
  output logic        alu_opcode,
  input  logic [7:0]  alu_out,
  input  logic        alu_done
);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] a_q, b_q;
  logic        sub_q;
  logic [7:0]  in_n;
  logic [31:0] data_n;
  logic        err_n;
  logic        accept;
  logic        expired;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign alu_start  = (state == START);
  assign resp_valid = (state == RESP);
  assign alu_opcode = (state inside {START, SEND, WAIT_DONE, RECV})
                    ? sub_q : OP_ADD;

  alu_host_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state != WAIT_DONE),
    .enable (state == WAIT_DONE),
    .expired(expired)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    in_n    = 8'h00;
    data_n  = resp_data;
    err_n   = resp_err;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = START;
          data_n  = '0;
          err_n   = 1'b0;
        end
      end
      START: begin
        state_n = SEND;
        cnt_n   = 3'd0;
        in_n    = send_byte(a_q, b_q, 3'd0);
      end
      SEND: begin
        if (cnt == 3'd7) begin
          state_n = WAIT_DONE;
          cnt_n   = 3'd0;
        end else begin
          cnt_n = cnt + 3'd1;
          in_n  = send_byte(a_q, b_q, cnt + 3'd1);
        end
      end
      WAIT_DONE: begin
        if (alu_done) begin
          data_n[7:0] = alu_out;
          state_n     = RECV;
          cnt_n       = 3'd1;
        end else if (expired) begin
          data_n  = '0;
          err_n   = 1'b1;
          state_n = RESP;
        end
      end
      RECV: begin
        if (alu_done) begin
          data_n[{cnt[1:0], 3'b000} +: 8] = alu_out;
          if (cnt == 3'(BYTES_PER_OPERAND - 1)) begin
            err_n   = 1'b0;
            state_n = RESP;
            cnt_n   = 3'd0;
          end else begin
            cnt_n = cnt + 3'd1;
          end
        end else begin
          // Short burst: report it, keep what arrived.
          err_n   = 1'b1;
          state_n = RESP;
          cnt_n   = 3'd0;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      alu_in    <= 8'h00;
      resp_data <= '0;
      resp_err  <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      alu_in    <= in_n;
      resp_data <= data_n;
      resp_err  <= err_n;
      if (accept) begin
        a_q   <= req_a;
        b_q   <= req_b;
        sub_q <= req_sub;
      end
    end
  end

endmodule

// File: tb/tb_alu_host_driver.sv
// Bench for alu_host_driver with a cycle-level byte-serial ALU model.
// FP math is modelled on integer-valued floats only.
module tb_alu_host_driver;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        req_sub = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        alu_start;
  logic [7:0]  alu_in;
  logic        alu_opcode;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_done = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_host_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_err  (resp_err),
    .alu_start (alu_start),
    .alu_in    (alu_in),
    .alu_opcode(alu_opcode),
    .alu_out   (alu_out),
    .alu_done  (alu_done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int f2i(input logic [31:0] f);
    int e;
    int m;
    if (f[30:23] == 8'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = int'({1'b1, f[22:0]}) >>> (23 - e);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] i2f(input int v);
    logic [31:0] m;
    int p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {(v < 0), 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  // ALU model: 0 normal, 1 never done, 2 done dropped after drop_n bytes
  int          mode = 0;
  int          drop_n = 0;
  int          ph = 0;
  logic [7:0]  cap[8];
  logic        op;
  logic [31:0] res;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      ph = 0;
      alu_done = 1'b0;
      alu_out = 8'h00;
    end else if (alu_start) begin
      ph = 1;
      op = alu_opcode;
    end else if (ph >= 1 && ph <= 8) begin
      cap[ph-1] = alu_in;
      ph++;
    end else if (ph == 9) begin
      res = op ? i2f(f2i({cap[3], cap[2], cap[1], cap[0]})
                   - f2i({cap[7], cap[6], cap[5], cap[4]}))
               : i2f(f2i({cap[3], cap[2], cap[1], cap[0]})
                   + f2i({cap[7], cap[6], cap[5], cap[4]}));
      ph++;
    end else if (ph >= 10 && ph <= 13) begin
      if (mode == 0 || (mode == 2 && ph - 10 < drop_n)) begin
        alu_done = 1'b1;
        alu_out = res[(ph-10)*8 +: 8];
      end else begin
        alu_done = 1'b0;
        alu_out = 8'h00;
      end
      ph++;
    end else begin
      alu_done = 1'b0;
      alu_out = 8'h00;
      ph = 0;
    end
  end

  task automatic txn(input logic [31:0] a, input logic [31:0] b,
                     input logic sub, input int md, input int dn,
                     input int bp, input string tag);
    logic [31:0] exp_res;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [63:0] w;
    int          exp_lat;
    int          lat;
    mode = md;
    drop_n = dn;
    w = {b, a};
    exp_res = sub ? i2f(f2i(a) - f2i(b)) : i2f(f2i(a) + f2i(b));
    case (md)
      0: begin exp_data = exp_res; exp_err = 1'b0; exp_lat = 15; end
      1: begin exp_data = 32'h0; exp_err = 1'b1; exp_lat = 10 + TO; end
      default: begin
        exp_data = exp_res & ((32'h1 << (8 * dn)) - 32'h1);
        exp_err = 1'b1;
        exp_lat = 12 + dn;
      end
    endcase
    chk({tag, ":req_ready"}, req_ready, 1);
    req_valid = 1'b1;
    req_a = a;
    req_b = b;
    req_sub = sub;
    resp_ready = (bp == 0);
    @(posedge clk); #1;
    lat = 1;
    req_a = $urandom;
    req_b = $urandom;
    req_sub = 1'($urandom);
    while (!resp_valid && lat < exp_lat + 5) begin
      chk({tag, ":start"}, alu_start, (lat == 1));
      chk({tag, ":opcode"}, alu_opcode, sub);
      chk({tag, ":busy_ready"}, req_ready, 0);
      if (lat >= 2 && lat <= 9) chk({tag, ":alu_in"}, alu_in, w[(lat-2)*8 +: 8]);
      else chk({tag, ":alu_in_idle"}, alu_in, 0);
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    chk({tag, ":latency"}, lat, exp_lat);
    chk({tag, ":resp_valid"}, resp_valid, 1);
    chk({tag, ":resp_data"}, resp_data, exp_data);
    chk({tag, ":resp_err"}, resp_err, exp_err);
    chk({tag, ":resp_opcode"}, alu_opcode, 0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({tag, ":bp_valid"}, resp_valid, 1);
      chk({tag, ":bp_data"}, resp_data, exp_data);
      chk({tag, ":bp_ready"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, ":after_valid"}, resp_valid, 0);
    chk({tag, ":after_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst:req_ready", req_ready, 1);
    chk("rst:resp_valid", resp_valid, 0);
    chk("rst:resp_data", resp_data, 0);
    chk("rst:resp_err", resp_err, 0);
    chk("rst:alu_start", alu_start, 0);
    chk("rst:alu_in", alu_in, 0);
    chk("rst:alu_opcode", alu_opcode, 0);
    chk("model:add", i2f(f2i(32'h3F800000) + f2i(32'h40000000)), 32'h40400000);

    txn(32'h3F800000, 32'h40000000, 1'b0, 0, 0, 0, "add");
    txn(32'h40400000, 32'h3F800000, 1'b1, 0, 0, 0, "sub");
    txn(i2f(7), i2f(-3), 1'b0, 1, 0, 0, "timeout");
    txn(i2f(100), i2f(25), 1'b1, 0, 0, 5, "bp");
    txn(i2f(300), i2f(-41), 1'b0, 2, 2, 0, "drop");

    mode = 0;
    req_valid = 1'b1;
    req_a = 32'h3F800000;
    req_b = 32'h40490FDB;
    req_sub = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid:byte5", alu_in, 8'h0F);
    rst = 1'b1;
    #1;
    chk("rst_mid:alu_start", alu_start, 0);
    chk("rst_mid:alu_in", alu_in, 0);
    chk("rst_mid:alu_opcode", alu_opcode, 0);
    chk("rst_mid:resp_valid", resp_valid, 0);
    chk("rst_mid:resp_data", resp_data, 0);
    chk("rst_mid:resp_err", resp_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid:req_ready", req_ready, 1);
    txn(32'h3F800000, 32'h3F800000, 1'b0, 0, 0, 1, "after_rst");

    for (int k = 0; k < 10; k++) begin
      txn(i2f(int'($urandom_range(2000)) - 1000),
          i2f(int'($urandom_range(2000)) - 1000),
          1'($urandom), (k % 4 == 3) ? int'($urandom_range(2, 1)) : 0,
          int'($urandom_range(3, 1)), int'($urandom_range(3)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
